// File: rtl/mbc1_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mbc1_bus_arbiter
// Desc     : Two-port cartridge bus arbiter/sequencer with MBC1 register shadow
// Revision : 1.0 - initial release
// ============================================================================
module mbc1_bus_arbiter #(
    parameter int SETUP_CYCLES  = 1,
    parameter int STROBE_CYCLES = 2,
    parameter int HOLD_CYCLES   = 1
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        CPU_REQ,
    input  logic        CPU_WE,
    input  logic [15:0] CPU_A,
    input  logic [7:0]  CPU_DO,
    output logic        CPU_ACK,
    output logic [7:0]  CPU_DI,
    input  logic        LD_REQ,
    input  logic        LD_WE,
    input  logic [15:0] LD_A,
    input  logic [7:0]  LD_DO,
    output logic        LD_ACK,
    output logic [7:0]  LD_DI,
    output logic [15:0] A,
    output logic [7:0]  D_OUT,
    output logic        D_OE,
    input  logic [7:0]  D_IN,
    output logic        n_WR,
    output logic        n_RD,
    output logic        n_CS,
    output logic        BUSY,
    output logic        GRANT,
    output logic        SH_RAMEN,
    output logic [4:0]  SH_BANK1,
    output logic [1:0]  SH_BANK2,
    output logic        SH_MODE,
    output logic [6:0]  ROM_BANK
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_STROBE = 2'd2,
        ST_HOLD   = 2'd3
    } state_t;

    localparam logic [3:0] c_setup_last  = 4'(SETUP_CYCLES - 1);
    localparam logic [3:0] c_strobe_last = 4'(STROBE_CYCLES - 1);
    localparam logic [3:0] c_hold_last   = 4'(HOLD_CYCLES - 1);

    state_t      r_state;
    logic [3:0]  r_cnt;
    logic        r_rr_ld;
    logic        r_grant;
    logic [15:0] r_addr;
    logic [7:0]  r_data;
    logic        r_we;
    logic [7:0]  r_rd_data;
    logic        r_oe;
    logic        r_wr_n;
    logic        r_rd_n;
    logic        r_cs_n;
    logic        r_busy;
    logic        r_cpu_ack;
    logic        r_ld_ack;
    logic [7:0]  r_cpu_di;
    logic [7:0]  r_ld_di;
    logic        r_ramen;
    logic [4:0]  r_bank1;
    logic [1:0]  r_bank2;
    logic        r_mode;
    logic [6:0]  r_rom_bank;

    state_t      w_state_nxt;
    logic [3:0]  w_cnt_nxt;
    logic        w_take;
    logic        w_grant_nxt;
    logic [15:0] w_addr_nxt;
    logic [7:0]  w_data_nxt;
    logic        w_we_nxt;
    logic        w_active;
    logic        w_ack_nxt;
    logic [7:0]  w_rd_val;
    logic        w_ramen_nxt;
    logic [4:0]  w_bank1_nxt;
    logic [1:0]  w_bank2_nxt;
    logic        w_mode_nxt;
    logic [6:0]  w_rom_nxt;

    // Next-state and transaction latch; r_rr_ld set means the loader wins a tie.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_take      = 1'b0;
        w_grant_nxt = r_grant;
        w_addr_nxt  = r_addr;
        w_data_nxt  = r_data;
        w_we_nxt    = r_we;
        case (r_state)
            ST_IDLE: begin
                if (CPU_REQ || LD_REQ) begin
                    w_take      = 1'b1;
                    w_grant_nxt = LD_REQ && (!CPU_REQ || r_rr_ld);
                    w_addr_nxt  = w_grant_nxt ? LD_A  : CPU_A;
                    w_data_nxt  = w_grant_nxt ? LD_DO : CPU_DO;
                    w_we_nxt    = w_grant_nxt ? LD_WE : CPU_WE;
                    w_state_nxt = ST_SETUP;
                    w_cnt_nxt   = 4'd0;
                end
            end
            ST_SETUP: begin
                if (r_cnt == c_setup_last) begin
                    w_state_nxt = ST_STROBE;
                    w_cnt_nxt   = 4'd0;
                end else begin
                    w_cnt_nxt = r_cnt + 4'd1;
                end
            end
            ST_STROBE: begin
                if (r_cnt == c_strobe_last) begin
                    w_state_nxt = ST_HOLD;
                    w_cnt_nxt   = 4'd0;
                end else begin
                    w_cnt_nxt = r_cnt + 4'd1;
                end
            end
            ST_HOLD: begin
                if (r_cnt == c_hold_last) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = 4'd0;
                end else begin
                    w_cnt_nxt = r_cnt + 4'd1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = 4'd0;
            end
        endcase
    end

    // Pin outputs are registered, so they are derived from the next state.
    assign w_active  = (w_state_nxt != ST_IDLE);
    assign w_ack_nxt = (w_state_nxt == ST_HOLD) && (w_cnt_nxt == c_hold_last);
    // With a single HOLD cycle the read sample and the ACK share one edge.
    assign w_rd_val  = (r_state == ST_STROBE) ? D_IN : r_rd_data;

    always_comb begin
        w_ramen_nxt = r_ramen;
        w_bank1_nxt = r_bank1;
        w_bank2_nxt = r_bank2;
        w_mode_nxt  = r_mode;
        if (w_ack_nxt && r_we) begin
            case (r_addr[15:13])
                3'd0:    w_ramen_nxt = (r_data[3:0] == 4'hA);
                3'd1:    w_bank1_nxt = r_data[4:0];
                3'd2:    w_bank2_nxt = r_data[1:0];
                3'd3:    w_mode_nxt  = r_data[0];
                default: w_mode_nxt  = r_mode;
            endcase
        end
        w_rom_nxt = {w_bank2_nxt, (w_bank1_nxt == 5'd0) ? 5'd1 : w_bank1_nxt};
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state    <= ST_IDLE;
            r_cnt      <= 4'd0;
            r_rr_ld    <= 1'b0;
            r_grant    <= 1'b0;
            r_addr     <= 16'h0000;
            r_data     <= 8'h00;
            r_we       <= 1'b0;
            r_rd_data  <= 8'h00;
            r_oe       <= 1'b0;
            r_wr_n     <= 1'b1;
            r_rd_n     <= 1'b1;
            r_cs_n     <= 1'b1;
            r_busy     <= 1'b0;
            r_cpu_ack  <= 1'b0;
            r_ld_ack   <= 1'b0;
            r_cpu_di   <= 8'h00;
            r_ld_di    <= 8'h00;
            r_ramen    <= 1'b0;
            r_bank1    <= 5'd0;
            r_bank2    <= 2'd0;
            r_mode     <= 1'b0;
            r_rom_bank <= 7'd1;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_grant   <= w_grant_nxt;
            r_addr    <= w_addr_nxt;
            r_data    <= w_data_nxt;
            r_we      <= w_we_nxt;
            if (w_take) begin
                r_rr_ld <= ~w_grant_nxt;
            end
            if (r_state == ST_STROBE && w_state_nxt == ST_HOLD) begin
                r_rd_data <= D_IN;
            end
            r_oe      <= w_active && w_we_nxt;
            r_wr_n    <= !((w_state_nxt == ST_STROBE) && w_we_nxt);
            r_rd_n    <= !((w_state_nxt == ST_STROBE) && !w_we_nxt);
            r_cs_n    <= !(w_active && (w_addr_nxt[15:13] == 3'b101));
            r_busy    <= w_active;
            r_cpu_ack <= w_ack_nxt && !w_grant_nxt;
            r_ld_ack  <= w_ack_nxt && w_grant_nxt;
            if (w_ack_nxt && !w_we_nxt) begin
                if (w_grant_nxt) begin
                    r_ld_di <= w_rd_val;
                end else begin
                    r_cpu_di <= w_rd_val;
                end
            end
            r_ramen    <= w_ramen_nxt;
            r_bank1    <= w_bank1_nxt;
            r_bank2    <= w_bank2_nxt;
            r_mode     <= w_mode_nxt;
            r_rom_bank <= w_rom_nxt;
        end
    end

    assign A        = r_addr;
    assign D_OUT    = r_data;
    assign D_OE     = r_oe;
    assign n_WR     = r_wr_n;
    assign n_RD     = r_rd_n;
    assign n_CS     = r_cs_n;
    assign BUSY     = r_busy;
    assign GRANT    = r_grant;
    assign CPU_ACK  = r_cpu_ack;
    assign LD_ACK   = r_ld_ack;
    assign CPU_DI   = r_cpu_di;
    assign LD_DI    = r_ld_di;
    assign SH_RAMEN = r_ramen;
    assign SH_BANK1 = r_bank1;
    assign SH_BANK2 = r_bank2;
    assign SH_MODE  = r_mode;
    assign ROM_BANK = r_rom_bank;

endmodule
`default_nettype wire

// File: tb/tb_mbc1_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mbc1_bus_arbiter
// Desc     : Vector table, corner sequences and randomized model check
// Revision : 1.0 - initial release
// ============================================================================
module tb_mbc1_bus_arbiter;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        CPU_REQ, CPU_WE, LD_REQ, LD_WE;
    logic [15:0] CPU_A, LD_A;
    logic [7:0]  CPU_DO, LD_DO, D_IN;
    logic        CPU_ACK, LD_ACK, D_OE, n_WR, n_RD, n_CS, BUSY, GRANT, SH_RAMEN, SH_MODE;
    logic [7:0]  CPU_DI, LD_DI, D_OUT;
    logic [15:0] A;
    logic [4:0]  SH_BANK1;
    logic [1:0]  SH_BANK2;
    logic [6:0]  ROM_BANK;

    logic        t2_req, t2_we;
    logic [15:0] t2_a;
    logic [7:0]  t2_do, t2_din;
    logic        t2_cpu_ack, t2_ld_ack, t2_oe, t2_wr_n, t2_rd_n, t2_cs_n, t2_busy, t2_grant;
    logic        t2_ramen, t2_mode;
    logic [7:0]  t2_cpu_di, t2_ld_di, t2_dout;
    logic [15:0] t2_addr;
    logic [4:0]  t2_bank1;
    logic [1:0]  t2_bank2;
    logic [6:0]  t2_rom;

    always #5 CLK = ~CLK;

    mbc1_bus_arbiter dut (
        .CLK(CLK), .RESET(RESET),
        .CPU_REQ(CPU_REQ), .CPU_WE(CPU_WE), .CPU_A(CPU_A), .CPU_DO(CPU_DO),
        .CPU_ACK(CPU_ACK), .CPU_DI(CPU_DI),
        .LD_REQ(LD_REQ), .LD_WE(LD_WE), .LD_A(LD_A), .LD_DO(LD_DO),
        .LD_ACK(LD_ACK), .LD_DI(LD_DI),
        .A(A), .D_OUT(D_OUT), .D_OE(D_OE), .D_IN(D_IN),
        .n_WR(n_WR), .n_RD(n_RD), .n_CS(n_CS), .BUSY(BUSY), .GRANT(GRANT),
        .SH_RAMEN(SH_RAMEN), .SH_BANK1(SH_BANK1), .SH_BANK2(SH_BANK2),
        .SH_MODE(SH_MODE), .ROM_BANK(ROM_BANK)
    );

    mbc1_bus_arbiter #(.SETUP_CYCLES(3), .STROBE_CYCLES(4), .HOLD_CYCLES(2)) dut2 (
        .CLK(CLK), .RESET(RESET),
        .CPU_REQ(t2_req), .CPU_WE(t2_we), .CPU_A(t2_a), .CPU_DO(t2_do),
        .CPU_ACK(t2_cpu_ack), .CPU_DI(t2_cpu_di),
        .LD_REQ(1'b0), .LD_WE(1'b0), .LD_A(16'h0000), .LD_DO(8'h00),
        .LD_ACK(t2_ld_ack), .LD_DI(t2_ld_di),
        .A(t2_addr), .D_OUT(t2_dout), .D_OE(t2_oe), .D_IN(t2_din),
        .n_WR(t2_wr_n), .n_RD(t2_rd_n), .n_CS(t2_cs_n), .BUSY(t2_busy), .GRANT(t2_grant),
        .SH_RAMEN(t2_ramen), .SH_BANK1(t2_bank1), .SH_BANK2(t2_bank2),
        .SH_MODE(t2_mode), .ROM_BANK(t2_rom)
    );

    typedef struct {
        bit          ld;
        bit          we;
        logic [15:0] a;
        logic [7:0]  d;
        logic [7:0]  din;
        int          wr;
        int          rd;
        int          cs;
        int          oe;
        logic [7:0]  di;
        bit          ramen;
        logic [4:0]  b1;
        logic [1:0]  b2;
        bit          mode;
        logic [6:0]  rom;
    } vec_t;

    localparam int NV = 11;
    vec_t vecs [NV];

    int total = 0;
    int bad   = 0;

    int m_ramen, m_b1, m_b2, m_mode, m_last;
    int m_di [2];
    logic        t_we [2];
    logic [15:0] t_a  [2];
    logic [7:0]  t_d  [2];
    logic [7:0]  cur_din;
    logic [31:0] rnd;
    int lat, wr, rd, cs, oe, first_lo;
    logic [7:0] di;
    bit a_ok, pend;
    int mask, order0, nreq, ndone, cyc, p, n;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(posedge CLK); #1;
        RESET = 1'b1;
        repeat (2) @(posedge CLK);
        #1 RESET = 1'b0;
    endtask

    task automatic check_shadows(input string tag);
        check({tag, "_ramen"}, 32'(SH_RAMEN), 32'(m_ramen));
        check({tag, "_bank1"}, 32'(SH_BANK1), 32'(m_b1));
        check({tag, "_bank2"}, 32'(SH_BANK2), 32'(m_b2));
        check({tag, "_mode"},  32'(SH_MODE),  32'(m_mode));
        check({tag, "_rom"},   32'(ROM_BANK), 32'(m_b2 * 32 + ((m_b1 == 0) ? 1 : m_b1)));
    endtask

    // One request on the default-parameter instance, profiled cycle by cycle.
    task automatic run_txn(input bit ld_p, input bit we_p, input logic [15:0] a_p,
                           input logic [7:0] d_p, input logic [7:0] din_p,
                           output int o_lat, output int o_wr, output int o_rd,
                           output int o_cs, output int o_oe, output logic [7:0] o_di,
                           output bit o_aok);
        o_lat = 0; o_wr = 0; o_rd = 0; o_cs = 0; o_oe = 0; o_di = 8'h00; o_aok = 1'b1;
        @(posedge CLK); #1;
        D_IN = din_p;
        if (ld_p) begin
            LD_REQ = 1'b1; LD_WE = we_p; LD_A = a_p; LD_DO = d_p;
        end else begin
            CPU_REQ = 1'b1; CPU_WE = we_p; CPU_A = a_p; CPU_DO = d_p;
        end
        @(posedge CLK);
        while (o_lat < 40) begin
            @(negedge CLK);
            o_lat++;
            if (!n_WR) o_wr++;
            if (!n_RD) o_rd++;
            if (!n_CS) o_cs++;
            if (D_OE)  o_oe++;
            if (A !== a_p || (we_p && D_OUT !== d_p)) o_aok = 1'b0;
            if (ld_p ? LD_ACK : CPU_ACK) begin
                o_di = ld_p ? LD_DI : CPU_DI;
                break;
            end
        end
        @(posedge CLK); #1;
        CPU_REQ = 1'b0;
        LD_REQ  = 1'b0;
        @(negedge CLK);
        check("ack_one_cycle", 32'({CPU_ACK, LD_ACK}), 32'd0);
        check("idle_busy", 32'(BUSY), 32'd0);
        check("idle_pins", 32'({n_CS, n_WR, n_RD, D_OE}), 32'b1110);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: bench did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        //               ld  we  a         d      din    wr rd cs oe di     ren b1     b2    md  rom
        vecs[0]  = '{1'b0, 1'b1, 16'h2000, 8'h00, 8'h00, 2, 0, 0, 4, 8'h00, 1'b0, 5'h00, 2'd0, 1'b0, 7'h01};
        vecs[1]  = '{1'b0, 1'b0, 16'hA123, 8'h00, 8'h5A, 0, 2, 4, 0, 8'h5A, 1'b0, 5'h00, 2'd0, 1'b0, 7'h01};
        vecs[2]  = '{1'b1, 1'b1, 16'h0000, 8'h0A, 8'h00, 2, 0, 0, 4, 8'h00, 1'b1, 5'h00, 2'd0, 1'b0, 7'h01};
        vecs[3]  = '{1'b1, 1'b1, 16'h4000, 8'h03, 8'h00, 2, 0, 0, 4, 8'h00, 1'b1, 5'h00, 2'd3, 1'b0, 7'h61};
        vecs[4]  = '{1'b0, 1'b1, 16'h6000, 8'h01, 8'h00, 2, 0, 0, 4, 8'h5A, 1'b1, 5'h00, 2'd3, 1'b1, 7'h61};
        vecs[5]  = '{1'b0, 1'b1, 16'h2000, 8'h1F, 8'h00, 2, 0, 0, 4, 8'h5A, 1'b1, 5'h1F, 2'd3, 1'b1, 7'h7F};
        vecs[6]  = '{1'b1, 1'b0, 16'hA000, 8'h00, 8'hC3, 0, 2, 4, 0, 8'hC3, 1'b1, 5'h1F, 2'd3, 1'b1, 7'h7F};
        vecs[7]  = '{1'b0, 1'b1, 16'h0000, 8'h0B, 8'h00, 2, 0, 0, 4, 8'h5A, 1'b0, 5'h1F, 2'd3, 1'b1, 7'h7F};
        vecs[8]  = '{1'b1, 1'b1, 16'h8000, 8'hFF, 8'h00, 2, 0, 0, 4, 8'hC3, 1'b0, 5'h1F, 2'd3, 1'b1, 7'h7F};
        vecs[9]  = '{1'b0, 1'b1, 16'hA5FF, 8'h77, 8'h00, 2, 0, 4, 4, 8'h5A, 1'b0, 5'h1F, 2'd3, 1'b1, 7'h7F};
        vecs[10] = '{1'b0, 1'b0, 16'h2000, 8'h00, 8'h99, 0, 2, 0, 0, 8'h99, 1'b0, 5'h1F, 2'd3, 1'b1, 7'h7F};

        RESET = 1'b0;
        CPU_REQ = 1'b0; CPU_WE = 1'b0; CPU_A = 16'h0000; CPU_DO = 8'h00;
        LD_REQ  = 1'b0; LD_WE  = 1'b0; LD_A  = 16'h0000; LD_DO  = 8'h00;
        D_IN = 8'h00;
        t2_req = 1'b0; t2_we = 1'b0; t2_a = 16'h0000; t2_do = 8'h00; t2_din = 8'h00;

        do_reset();
        @(negedge CLK);
        check("rst_a", 32'(A), 32'h0000);
        check("rst_dout", 32'(D_OUT), 32'h00);
        check("rst_pins", 32'({D_OE, n_WR, n_RD, n_CS}), 32'b0111);
        check("rst_acks", 32'({CPU_ACK, LD_ACK}), 32'd0);
        check("rst_dis", 32'({CPU_DI, LD_DI}), 32'h0000);
        check("rst_busy_grant", 32'({BUSY, GRANT}), 32'd0);
        check("rst_shadows", 32'({SH_RAMEN, SH_BANK1, SH_BANK2, SH_MODE}), 32'd0);
        check("rst_rom", 32'(ROM_BANK), 32'd1);

        for (int i = 0; i < NV; i++) begin
            run_txn(vecs[i].ld, vecs[i].we, vecs[i].a, vecs[i].d, vecs[i].din,
                    lat, wr, rd, cs, oe, di, a_ok);
            check($sformatf("vec%0d_lat", i),   32'(lat), 32'd4);
            check($sformatf("vec%0d_wr", i),    32'(wr),  32'(vecs[i].wr));
            check($sformatf("vec%0d_rd", i),    32'(rd),  32'(vecs[i].rd));
            check($sformatf("vec%0d_cs", i),    32'(cs),  32'(vecs[i].cs));
            check($sformatf("vec%0d_oe", i),    32'(oe),  32'(vecs[i].oe));
            check($sformatf("vec%0d_di", i),    32'(di),  32'(vecs[i].di));
            check($sformatf("vec%0d_aout", i),  32'(a_ok), 32'd1);
            check($sformatf("vec%0d_grant", i), 32'(GRANT), 32'(vecs[i].ld));
            check($sformatf("vec%0d_shadow", i), 32'({SH_RAMEN, SH_BANK1, SH_BANK2, SH_MODE}),
                  32'({vecs[i].ramen, vecs[i].b1, vecs[i].b2, vecs[i].mode}));
            check($sformatf("vec%0d_rom", i),   32'(ROM_BANK), 32'(vecs[i].rom));
        end

        // Both requesters held high: alternating grants five cycles apart.
        do_reset();
        @(posedge CLK); #1;
        CPU_REQ = 1'b1; CPU_WE = 1'b0; CPU_A = 16'hA001;
        LD_REQ  = 1'b1; LD_WE  = 1'b1; LD_A  = 16'h8000; LD_DO = 8'h11;
        D_IN = 8'h42;
        @(posedge CLK);
        n = 0; cyc = 0;
        while (n < 4 && cyc < 40) begin
            @(negedge CLK);
            cyc++;
            if (CPU_ACK && LD_ACK) begin
                check("rr_dual_ack", 32'({CPU_ACK, LD_ACK}), 32'd0);
            end else if (CPU_ACK || LD_ACK) begin
                check("rr_owner", 32'(LD_ACK), 32'(n % 2));
                check("rr_grant", 32'(GRANT), 32'(n % 2));
                check("rr_time", 32'(cyc), 32'(4 + 5 * n));
                n++;
            end
        end
        check("rr_count", 32'(n), 32'd4);
        @(posedge CLK); #1;
        CPU_REQ = 1'b0; LD_REQ = 1'b0;

        // Reset during STROBE of a bank-1 write, with the request still high.
        @(posedge CLK); #1;
        CPU_REQ = 1'b1; CPU_WE = 1'b1; CPU_A = 16'h2000; CPU_DO = 8'h05;
        @(posedge CLK);
        @(negedge CLK);
        @(negedge CLK);
        check("mid_in_strobe", 32'(n_WR), 32'd0);
        @(posedge CLK); #1;
        RESET = 1'b1;
        @(posedge CLK); #1;
        RESET = 1'b0;
        CPU_REQ = 1'b0;
        @(negedge CLK);
        check("mid_pins", 32'({n_WR, n_RD, D_OE}), 32'b110);
        check("mid_busy", 32'(BUSY), 32'd0);
        check("mid_bank1", 32'(SH_BANK1), 32'd0);
        n = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge CLK);
            if (CPU_ACK || LD_ACK) n++;
        end
        check("mid_no_ack", 32'(n), 32'd0);

        // Randomized traffic against a rule-level model.
        do_reset();
        m_ramen = 0; m_b1 = 0; m_b2 = 0; m_mode = 0;
        m_di[0] = 0; m_di[1] = 0;
        m_last = 1;
        for (int it = 0; it < 40; it++) begin
            mask = int'($urandom_range(1, 3));
            @(posedge CLK); #1;
            rnd = $urandom; cur_din = rnd[7:0]; D_IN = cur_din;
            for (int q = 0; q < 2; q++) begin
                rnd = $urandom;
                t_we[q] = rnd[24]; t_a[q] = rnd[15:0]; t_d[q] = rnd[23:16];
            end
            if (mask != 2) begin
                CPU_REQ = 1'b1; CPU_WE = t_we[0]; CPU_A = t_a[0]; CPU_DO = t_d[0];
            end
            if (mask != 1) begin
                LD_REQ = 1'b1; LD_WE = t_we[1]; LD_A = t_a[1]; LD_DO = t_d[1];
            end
            nreq   = (mask == 3) ? 2 : 1;
            order0 = (mask == 3) ? ((m_last == 1) ? 0 : 1) : ((mask == 2) ? 1 : 0);
            @(posedge CLK);
            ndone = 0; cyc = 0; pend = 1'b0;
            while (ndone < nreq && cyc < 30) begin
                @(negedge CLK);
                cyc++;
                if (pend) begin
                    check_shadows("rnd");
                    pend = 1'b0;
                end
                if (CPU_ACK && LD_ACK) begin
                    check("rnd_dual_ack", 32'({CPU_ACK, LD_ACK}), 32'd0);
                end else if (CPU_ACK || LD_ACK) begin
                    p = LD_ACK ? 1 : 0;
                    check("rnd_owner", 32'(p), 32'((ndone == 0) ? order0 : 1 - order0));
                    check("rnd_ack_time", 32'(cyc), 32'(4 + 5 * ndone));
                    check("rnd_addr", 32'(A), 32'(t_a[p]));
                    check("rnd_cs", 32'(n_CS), 32'((t_a[p] >= 16'hA000 && t_a[p] <= 16'hBFFF) ? 0 : 1));
                    check("rnd_oe", 32'(D_OE), 32'(t_we[p]));
                    m_last = p;
                    if (t_we[p]) begin
                        if (t_a[p] < 16'h2000)      m_ramen = ((t_d[p] % 16) == 10) ? 1 : 0;
                        else if (t_a[p] < 16'h4000) m_b1 = t_d[p] % 32;
                        else if (t_a[p] < 16'h6000) m_b2 = t_d[p] % 4;
                        else if (t_a[p] < 16'h8000) m_mode = t_d[p] % 2;
                    end else begin
                        m_di[p] = cur_din;
                    end
                    check("rnd_cpu_di", 32'(CPU_DI), 32'(m_di[0]));
                    check("rnd_ld_di", 32'(LD_DI), 32'(m_di[1]));
                    pend = 1'b1;
                    ndone++;
                    @(posedge CLK); #1;
                    if (p == 0) CPU_REQ = 1'b0;
                    else        LD_REQ  = 1'b0;
                    rnd = $urandom; cur_din = rnd[7:0]; D_IN = cur_din;
                end
            end
            check("rnd_done", 32'(ndone), 32'(nreq));
            if (pend) begin
                @(negedge CLK);
                check_shadows("rnd");
            end
            CPU_REQ = 1'b0; LD_REQ = 1'b0;
        end

        // Stretched timing instance: SETUP=3, STROBE=4, HOLD=2.
        @(posedge CLK); #1;
        t2_req = 1'b1; t2_we = 1'b1; t2_a = 16'h2000; t2_do = 8'h03;
        @(posedge CLK);
        lat = 0; wr = 0; first_lo = 0;
        while (lat < 40) begin
            @(negedge CLK);
            lat++;
            if (!t2_wr_n) begin
                wr++;
                if (first_lo == 0) first_lo = lat;
            end
            if (t2_cpu_ack) break;
        end
        check("long_wr_lat", 32'(lat), 32'd9);
        check("long_wr_low", 32'(wr), 32'd4);
        check("long_wr_first", 32'(first_lo), 32'd4);
        @(posedge CLK); #1;
        t2_req = 1'b0;
        @(negedge CLK);
        check("long_ack_off", 32'(t2_cpu_ack), 32'd0);
        check("long_bank1", 32'(t2_bank1), 32'd3);
        check("long_rom", 32'(t2_rom), 32'd3);

        @(posedge CLK); #1;
        t2_req = 1'b1; t2_we = 1'b0; t2_a = 16'hA000; t2_din = 8'h3C;
        @(posedge CLK);
        lat = 0; rd = 0; cs = 0;
        while (lat < 40) begin
            @(negedge CLK);
            lat++;
            if (!t2_rd_n) rd++;
            if (!t2_cs_n) cs++;
            if (lat == 8) t2_din = 8'hFF;
            if (t2_cpu_ack) break;
        end
        check("long_rd_lat", 32'(lat), 32'd9);
        check("long_rd_low", 32'(rd), 32'd4);
        check("long_rd_cs", 32'(cs), 32'd9);
        check("long_rd_di", 32'(t2_cpu_di), 32'h3C);
        @(posedge CLK); #1;
        t2_req = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mbc1_bus_arbiter.md
# mbc1_bus_arbiter

Synchronous cartridge-bus controller in front of the MBC1 mapper. It arbitrates between two requesters, the CPU port and the loader/debug port, and sequences each granted access into a setup/strobe/hold cycle on the cartridge pins (A, D, n_WR, n_RD, n_CS). It also keeps a shadow copy of the MBC1 control registers, so the rest of the design knows the current banking state without reading the mapper back.

## Interface
Parameters:
- SETUP_CYCLES, 1, cycles with address valid before the strobe; legal range 1–15
- STROBE_CYCLES, 2, cycles with n_WR/n_RD low; legal range 1–15
- HOLD_CYCLES, 1, cycles with address/data held after the strobe; legal range 1–15

Ports:
- CLK  in  1  single clock; all state changes on the rising edge
- RESET  in  1  synchronous, active-high reset
- CPU_REQ, LD_REQ  in  1  request; held high until the matching ACK
- CPU_WE, LD_WE  in  1  1 = write, 0 = read
- CPU_A, LD_A  in  16  byte address
- CPU_DO, LD_DO  in  8  write data
- CPU_ACK, LD_ACK  out  1  one-cycle completion pulse
- CPU_DI, LD_DI  out  8  read data; valid while ACK is high, held until the next read for that port
- A  out  16  cartridge address
- D_OUT  out  8  cartridge write data
- D_OE  out  1  data pad output enable
- D_IN  in  8  cartridge read data
- n_WR, n_RD, n_CS  out  1  active-low strobes; n_CS low only for A in 0xA000–0xBFFF
- BUSY  out  1  high in any state other than IDLE
- GRANT  out  1  current or last owner: 0 = CPU, 1 = loader
- SH_RAMEN  out  1  RAM enable shadow
- SH_BANK1  out  5  raw bank-1 value
- SH_BANK2  out  2  bank-2 value
- SH_MODE  out  1  mode bit
- ROM_BANK  out  7  {SH_BANK2, (SH_BANK1==0 ? 5'd1 : SH_BANK1)}

## Operation
- FSM states: IDLE, SETUP, STROBE, HOLD. A single 4-bit counter times each phase.
- IDLE, arbitration:
  - If any REQ is high, grant one requester.
  - If both are high, round-robin: the requester not granted last time wins. After reset, the CPU wins.
  - Latch address, data and WE; set GRANT; go to SETUP.
- SETUP, for SETUP_CYCLES cycles:
  - A is set to the latched address.
  - n_CS follows the address decode.
  - D_OUT = latched data; D_OE = WE.
  - n_WR and n_RD stay high.
- STROBE, for STROBE_CYCLES cycles:
  - Write: n_WR low. Read: n_RD low.
  - Reads sample D_IN at the end of the last STROBE cycle.
- HOLD, for HOLD_CYCLES cycles:
  - Strobes high; A, n_CS, D_OUT and D_OE held.
  - The granted ACK is high during the last HOLD cycle, and DI is updated for reads.
  - Then go to IDLE.
- In IDLE: n_CS high, D_OE low, n_WR/n_RD high, A and D_OUT keep their last values.
- Shadow update happens in the ACK cycle, for writes only, by address range:
  - 0x0000–0x1FFF: SH_RAMEN = (D[3:0]==4'hA).
  - 0x2000–0x3FFF: SH_BANK1 = D[4:0].
  - 0x4000–0x5FFF: SH_BANK2 = D[1:0].
  - 0x6000–0x7FFF: SH_MODE = D[0].
  - All other addresses leave the shadows unchanged.
- Requesters must keep REQ/A/DO/WE stable until ACK. Changes after the grant are ignored. A REQ dropped before its ACK still completes the bus cycle and still pulses ACK.

## Timing
- Reset values:
  - A = 0x0000, D_OUT = 0x00, D_OE = 0, n_WR = n_RD = n_CS = 1.
  - ACKs = 0, DIs = 0x00, BUSY = 0, GRANT = 0.
  - All shadows = 0, so ROM_BANK = 7'd1. Round-robin pointer favours the CPU.
- All outputs are registered.
- Latency: REQ sampled high in IDLE at edge N → SETUP starts at N+1 → ACK high in cycle N + SETUP + STROBE + HOLD. With default parameters this is N+4.
- Back-to-back: IDLE lasts at least one cycle between transactions (bus turnaround). With defaults, an accepted request completes every 5 cycles.
- RESET asserted mid-transaction:
  - Next edge returns to IDLE with strobes high and D_OE low.
  - No ACK is issued and the shadows are not updated.
  - The requester must re-request.
- RESET takes precedence over any simultaneous REQ or ACK event.

## Test plan
- Single CPU write of A=0x2000, D=0x00 (defaults) → SETUP 1 cycle, n_WR low exactly 2 cycles, CPU_ACK at N+4, SH_BANK1=0, ROM_BANK=7'd1.
- CPU read of A=0xA123 with D_IN=0x5A → n_CS low and n_RD low for 2 cycles, CPU_DI=0x5A at ACK, D_OE low throughout.
- CPU_REQ and LD_REQ high together, repeatedly → grants alternate CPU, LD, CPU, LD; each ACK 5 cycles apart; never both ACKs high at once.
- Writes 0x0000←0x0A, 0x4000←0x03, 0x6000←0x01, 0x2000←0x1F → SH_RAMEN=1, SH_BANK2=3, SH_MODE=1, ROM_BANK=7'h7F. Then a write 0x0000←0x0B → SH_RAMEN=0.
- RESET pulsed during STROBE of a write to 0x2000 with D=0x05 → next cycle n_WR=1, no ACK, SH_BANK1 stays 0, BUSY=0.
- SETUP=3, STROBE=4, HOLD=2 → strobe low exactly 4 cycles, ACK at N+9.
